// File: rtl/i2c_arbiter.sv
// Round-robin arbiter that shares one I2C master between NUM_REQ requesters.
// Latches the winner's command, pulses the master enable and returns the result with a watchdog.
module i2c_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int data_wd = 8,
  parameter int addr_wd = 7,
  parameter int TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         req_rw,
  input  logic [NUM_REQ*data_wd-1:0] req_wdata,
  input  logic [NUM_REQ*addr_wd-1:0] req_addr,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [data_wd-1:0]         rsp_rdata,
  output logic                       rsp_err,
  output logic                       busy,
  output logic                       i2c_en,
  output logic                       i2c_r_w,
  output logic [data_wd-1:0]         i2c_wdata,
  output logic [addr_wd-1:0]         i2c_addr,
  input  logic [data_wd-1:0]         i2c_rdata,
  input  logic                       i2c_done
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]         r_state;
  logic [IW-1:0]      r_ptr;
  logic [IW-1:0]      r_idx;
  logic [CW-1:0]      r_cnt;
  logic [NUM_REQ-1:0] r_gnt;
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic [data_wd-1:0] r_rsp_rdata;
  logic               r_rsp_err;
  logic               r_busy;
  logic               r_en;
  logic               r_rw;
  logic [data_wd-1:0] r_wdata;
  logic [addr_wd-1:0] r_addr;

  logic               w_any;
  logic [IW-1:0]      w_idx;
  logic [NUM_REQ-1:0] w_sel_oh;
  logic [NUM_REQ-1:0] w_idx_oh;
  logic [IW-1:0]      w_ptr_nxt;
  logic               w_expired;

  // First pending request at or after the pointer, wrapping around.
  always_comb begin
    int j;
    j     = 0;
    w_any = 1'b0;
    w_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(r_ptr) + k) % NUM_REQ;
      if (!w_any && req[j]) begin
        w_any = 1'b1;
        w_idx = IW'(j);
      end
    end
  end

  assign w_sel_oh  = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_idx;
  assign w_idx_oh  = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_idx;
  assign w_ptr_nxt = (r_idx == IW'(NUM_REQ-1)) ? '0 : r_idx + 1'b1;
  assign w_expired = (r_cnt == CW'(TIMEOUT-1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_gnt       <= '0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_busy      <= 1'b0;
      r_en        <= 1'b0;
      r_rw        <= 1'b0;
      r_wdata     <= '0;
      r_addr      <= '0;
    end else begin
      r_gnt       <= '0;
      r_en        <= 1'b0;
      r_rsp_valid <= '0;
      case (r_state)
        S_IDLE: begin
          // Grant and enable leave together so the master starts in the grant cycle.
          if (w_any) begin
            r_idx   <= w_idx;
            r_rw    <= req_rw[w_idx];
            r_wdata <= req_wdata[int'(w_idx)*data_wd +: data_wd];
            r_addr  <= req_addr[int'(w_idx)*addr_wd +: addr_wd];
            r_gnt   <= w_sel_oh;
            r_en    <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          // Done is tested first so it wins over a coincident expiry.
          if (i2c_done) begin
            r_rsp_rdata <= r_rw ? i2c_rdata : '0;
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= w_idx_oh;
            r_state     <= S_RESP;
          end else if (w_expired) begin
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= w_idx_oh;
            r_state     <= S_RESP;
          end
        end
        S_RESP: begin
          r_ptr   <= w_ptr_nxt;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign busy      = r_busy;
  assign i2c_en    = r_en;
  assign i2c_r_w   = r_rw;
  assign i2c_wdata = r_wdata;
  assign i2c_addr  = r_addr;

endmodule

// File: tb/tb_i2c_arbiter.sv
// Bench for i2c_arbiter: a reactive master model plus a queue of expected responses.
module tb_i2c_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 7;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req;
  logic [N-1:0]  req_rw;
  logic [N*DW-1:0] req_wdata;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]  gnt;
  logic [N-1:0]  rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          busy;
  logic          i2c_en;
  logic          i2c_r_w;
  logic [DW-1:0] i2c_wdata;
  logic [AW-1:0] i2c_addr;
  logic [DW-1:0] i2c_rdata;
  logic          i2c_done;

  i2c_arbiter #(.NUM_REQ(N), .data_wd(DW), .addr_wd(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_rw(req_rw),
    .req_wdata(req_wdata), .req_addr(req_addr), .gnt(gnt),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy(busy), .i2c_en(i2c_en), .i2c_r_w(i2c_r_w), .i2c_wdata(i2c_wdata),
    .i2c_addr(i2c_addr), .i2c_rdata(i2c_rdata), .i2c_done(i2c_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       idx;
    logic [7:0] rdata;
    logic     err;
    int       lat;
  } exp_t;

  exp_t q[$];
  int   order[$];
  int   n_tot = 0;
  int   n_bad = 0;
  int   m_ptr = 0;
  int   gcnt = 0;
  int   lat = 0;
  int   m_dly = 4;
  int   cur_idx = 0;
  bit   m_hold = 0;
  bit   m_nodone = 0;
  bit   cur_nodone = 0;
  bit   active = 0;
  bit   done_up = 0;
  logic          m_rw = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [7:0] rd_val(input int i);
    return (i == 2) ? 8'h3C : 8'(8'h90 + i);
  endfunction

  // One clock: sample outputs just after the edge, check them, react as the master.
  task automatic tick();
    exp_t e;
    int   k;
    @(posedge clk);
    #1;
    if (done_up) begin
      i2c_done  = 1'b0;
      i2c_rdata = 8'hEE;
      done_up   = 1'b0;
    end
    if (active) begin
      lat++;
      if (rsp_valid != '0) begin
        if (q.size() == 0) begin
          chk("rsp_unexp", 64'(rsp_valid), 64'd0);
        end else begin
          e = q.pop_front();
          chk("rsp_vld", 64'(rsp_valid), 64'd1 << e.idx);
          chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
          chk("rsp_err", 64'(rsp_err), 64'(e.err));
          chk("rsp_lat", 64'(lat), 64'(e.lat));
          chk("rsp_busy", 64'(busy), 64'd1);
        end
        active = 0;
      end else begin
        chk("wait_hold", 64'({gnt, i2c_en, i2c_r_w, i2c_addr, i2c_wdata, busy}),
            64'({4'b0, 1'b0, m_rw, m_addr, m_wdata, 1'b1}));
        if (!cur_nodone && lat == m_dly) begin
          i2c_done  = 1'b1;
          i2c_rdata = rd_val(cur_idx);
          done_up   = 1'b1;
        end
        if (lat > TO + 4) begin
          chk("rsp_missing", 64'(lat), 64'(TO + 1));
          active = 0;
        end
      end
    end else if (rsp_valid != '0) begin
      chk("rsp_unexp", 64'(rsp_valid), 64'd0);
    end
    if (gnt != '0) begin
      k = pick(req, m_ptr);
      chk("gnt", 64'(gnt), (k < 0) ? 64'd0 : (64'd1 << k));
      if (k < 0) k = 0;
      chk("gnt_en_busy", 64'({i2c_en, busy}), 64'd3);
      chk("gnt_fields", 64'({i2c_r_w, i2c_addr, i2c_wdata}),
          64'({req_rw[k], req_addr[k*AW +: AW], req_wdata[k*DW +: DW]}));
      m_rw       = req_rw[k];
      m_addr     = req_addr[k*AW +: AW];
      m_wdata    = req_wdata[k*DW +: DW];
      cur_idx    = k;
      cur_nodone = m_nodone;
      m_nodone   = 0;
      lat        = 0;
      active     = 1;
      order.push_back(k);
      gcnt++;
      e.idx   = k;
      e.err   = cur_nodone || (m_dly > TO);
      e.rdata = (e.err || !m_rw) ? 8'h00 : rd_val(k);
      e.lat   = e.err ? TO + 1 : m_dly + 1;
      q.push_back(e);
      m_ptr = (k + 1) % N;
      if (!m_hold) begin
        req[k] = 1'b0;
        req_wdata[k*DW +: DW] = ~req_wdata[k*DW +: DW];
      end
    end
  endtask

  task automatic wait_idle(input string tag);
    bit ok;
    ok = 0;
    for (int c = 0; c < 400; c++) begin
      if (req == '0 && !active && q.size() == 0) begin
        ok = 1;
        break;
      end
      tick();
    end
    if (!ok) chk({tag, "_stall"}, 64'd1, 64'd0);
    tick();
  endtask

  int exp_rr[8] = '{0, 1, 2, 3, 0, 1, 3, 1};

  initial begin
    int base;
    rst_n     = 1'b0;
    req       = '0;
    req_rw    = 4'b0110;
    i2c_done  = 1'b0;
    i2c_rdata = 8'hEE;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW]  = 7'(8'h40 + i);
      req_wdata[i*DW +: DW] = 8'(8'h11 * (i + 1));
    end
    repeat (3) tick();
    chk("rst_state", 64'({gnt, rsp_valid, rsp_rdata, rsp_err, busy, i2c_en, i2c_r_w, i2c_wdata, i2c_addr}), 64'd0);
    rst_n = 1'b1;
    tick();

    // single write on requester 0
    req_addr[0*AW +: AW] = 7'h50;
    req_wdata[0*DW +: DW] = 8'hA5;
    req_rw[0] = 1'b0;
    m_dly = 10;
    req[0] = 1'b1;
    wait_idle("write");

    // read on requester 2
    req_addr[2*AW +: AW] = 7'h51;
    req_rw[2] = 1'b1;
    m_dly = 5;
    req[2] = 1'b1;
    wait_idle("read");

    // write on requester 3 brings the pointer back to 0
    m_dly = 4;
    req[3] = 1'b1;
    wait_idle("w3");

    // round robin with requests held continuously
    base = order.size();
    m_dly  = 3;
    m_hold = 1;
    gcnt   = 0;
    req    = 4'b1111;
    for (int c = 0; c < 400 && gcnt < 5; c++) tick();
    req = 4'b1010;
    for (int c = 0; c < 400 && gcnt < 8; c++) tick();
    req    = '0;
    m_hold = 0;
    wait_idle("rr");
    for (int i = 0; i < 8; i++) begin
      if (base + i < order.size()) chk("rr_order", 64'(order[base + i]), 64'(exp_rr[i]));
      else chk("rr_missing", 64'(i), 64'd8);
    end

    // timeout on requester 3, then pending requester 1 is served
    base     = order.size();
    m_dly    = 6;
    m_nodone = 1;
    req      = 4'b1010;
    wait_idle("timeout");
    chk("to_order", 64'({order.size() > base + 1 ? order[base] : -1,
                          order.size() > base + 1 ? order[base + 1] : -1}), {32'd3, 32'd1});

    // done arriving on the expiry cycle wins
    req_rw[0] = 1'b1;
    m_dly = TO;
    req[0] = 1'b1;
    wait_idle("expiry");

    // spurious done while idle
    i2c_done = 1'b1;
    repeat (3) begin
      tick();
      chk("spur_idle", 64'({rsp_valid, busy, gnt}), 64'd0);
    end
    i2c_done = 1'b0;
    chk("hold_rdata", 64'({rsp_rdata, rsp_err}), 64'({8'h90, 1'b0}));

    // reset in the middle of WAIT
    m_nodone = 1;
    req[2] = 1'b1;
    for (int c = 0; c < 20 && !active; c++) tick();
    chk("rstw_started", 64'(active), 64'd1);
    repeat (5) tick();
    rst_n  = 1'b0;
    active = 0;
    q.delete();
    m_ptr  = 0;
    tick();
    chk("rst_wait", 64'({gnt, rsp_valid, rsp_rdata, rsp_err, busy, i2c_en, i2c_r_w, i2c_wdata, i2c_addr}), 64'd0);
    tick();
    rst_n = 1'b1;
    repeat (3) begin
      tick();
      chk("post_rst_quiet", 64'({rsp_valid, busy}), 64'd0);
    end

    // pointer restarts at 0 after reset
    base     = order.size();
    m_nodone = 0;
    m_dly    = 2;
    req      = 4'b1111;
    wait_idle("post_rst");
    chk("post_rst_first", 64'(order.size() > base ? order[base] : -1), 64'd0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required finish before it");
    $fatal(1);
  end

endmodule
